instr_mem_loader: RTL
=====================

# instr_mem_loader

Parametrised instruction memory for the single-cycle MIPS core that replaces the hard-coded program ROM with a runtime-loadable array. A byte-stream loader port with valid/ready handshake assembles big-endian instruction words, writes them sequentially from address 0, then zero-fills the remainder of the array. The CPU is held off via `cpu_hold` until a load completes. The read port keeps the existing combinational fetch contract, so the datapath is unchanged.

## Interface
- `ADDR_W`, 8, instruction address width; depth = 2^ADDR_W words
- `DATA_W`, 32, instruction width; must be a multiple of 8; BYTES = DATA_W/8

- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instruction_address`  in  ADDR_W  fetch word address
- `instruction`  out  DATA_W  fetched word, combinational
- `load_start`  in  1  single-cycle pulse; begins a new program load
- `load_valid`  in  1  `load_byte` is valid
- `load_byte`  in  8  program byte, most-significant byte of each word first
- `load_last`  in  1  qualifies the final byte of the program
- `load_ready`  out  1  loader accepts a byte this cycle
- `cpu_hold`  out  1  CPU must stall and hold its PC at 0
- `load_done`  out  1  one-cycle pulse when a load completes
- `load_error`  out  1  sticky overflow flag; cleared by `load_start` or reset

## Operation
- FSM states: HOLD, LOAD, FILL, RUN.
- Reset: state = HOLD; `cpu_hold`=1; `load_ready`=0; `load_done`=0; `load_error`=0; word pointer=0; byte counter=0. Array contents are not reset.
- **HOLD or RUN + `load_start`:** go to LOAD, pointer=0, byte counter=0, clear `load_error`, set `cpu_hold`=1.
- **LOAD:** `load_ready`=1. A byte is accepted on `load_valid && load_ready`.
  - Bytes shift into the assembly register; byte k of a word lands in bits [DATA_W-1-8k -: 8].
  - On acceptance of byte BYTES-1, write the assembled word to mem[pointer], increment the pointer, and clear the byte counter.
  - If `load_last` arrives on a partial word, zero-pad the unused low bytes and write that word.
  - After the last byte is written, go to FILL. If the pointer wrapped to 0 (array full), go directly to RUN.
- **Overflow:** a byte accepted after all 2^ADDR_W words are written is dropped and sets `load_error`. If it carries `load_last`, go to RUN.
- **FILL:** `load_ready`=0. Write 0 (NOP) to mem[pointer] and increment, one word per cycle. After writing address 2^ADDR_W−1, go to RUN.
- **Entering RUN:** pulse `load_done` for one cycle; `cpu_hold`=0.
- **Read:** `instruction` = mem[`instruction_address`] while `cpu_hold`=0. It is forced to 0 while `cpu_hold`=1.
- **Precedence:** `load_start` is ignored in LOAD and FILL. A `load_valid` outside LOAD is ignored.
- **Reset mid-load:** returns to HOLD. The partially written array is left as-is and must be reloaded.

## Timing
- Byte handshake has 0-cycle latency: the word write occurs on the same edge as acceptance of its final byte.
- `cpu_hold` falls on the edge entering RUN; the first fetch of mem[0] is valid in that cycle.
- **Full load, N bytes:** ceil(N/BYTES) words are written. FILL then takes 2^ADDR_W − ceil(N/BYTES) cycles.
- `load_done` is high for exactly the first RUN cycle.
- The read path is purely combinational: no clock latency from `instruction_address` to `instruction`.

## Structure
- The shared package `mips_pkg` holds:
  - the loader state enum (HOLD/LOAD/FILL/RUN),
  - `NOP_WORD` = 0,
  - default `ADDR_W`/`DATA_W`.
- One sub-module, `byte_word_assembler`, contains the byte counter, shift/pad logic and the word-complete strobe. The FSM, pointer and array stay in the top module.

## Test plan
- **Reset then load:** stream the 8 bytes 20 10 00 78 AC 12 00 00, then `load_last` → mem[0]=32'h20100078, mem[1]=32'hAC120000, mem[2..255]=0. `load_done` pulses once, then `cpu_hold`=0.
- **Partial word:** 6 bytes 00 00 80 20 12 11 + `load_last` → mem[1]=32'h12110000.
- **Backpressure gaps:** deassert `load_valid` randomly mid-word → same array contents as the gap-free load; no byte is duplicated or lost.
- **Overflow:** ADDR_W=2, stream 20 bytes → mem[0..3] hold the first 16 bytes, `load_error`=1, FSM in RUN, no FILL cycles.
- **Reload and hold:** second `load_start` while in RUN → `cpu_hold`=1 and `instruction`=0 until the new `load_done`; the old contents are fully overwritten or zero-filled.
- **Async reset mid-FILL:** assert `rst_n`=0 → `cpu_hold`=1 and `load_ready`=0 immediately; state HOLD after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the runtime-loadable MIPS instruction memory:
// loader state encoding, the NOP fill word and default geometry.
package mips_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // All-zero word decodes as sll $0,$0,0, i.e. a NOP.
  localparam int unsigned NOP_WORD = 0;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a big-endian byte stream into DATA_W-bit words; strobes when a word
// is complete or the stream ends on a partial word (low bytes zero-padded).
module byte_word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_strobe_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;

  // Word as it would look with the current byte merged in; slots past the
  // current byte are always zero, which gives the padding for free.
  always_comb begin
    word_o = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        word_o[DATA_W-1-8*k -: 8] = byte_i;
      end else if (CNT_W'(k) < cnt_q) begin
        word_o[DATA_W-1-8*k -: 8] = asm_q[DATA_W-1-8*k -: 8];
      end
    end
  end

  assign word_strobe_o = accept_i && (last_i || (cnt_q == LAST_IDX));

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i || word_strobe_o) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      asm_d = word_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Runtime-loadable instruction memory: byte-stream loader, NOP fill of the
// unused tail, and a combinational fetch port gated by cpu_hold.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] instruction_address,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
  // load_ready is high exactly while the FSM is in LOAD and never depends on
  // load_valid. The word write happens on that same edge.

  loader_state_e     state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              full_q;
  logic              cpu_hold_q;
  logic              load_ready_q;
  logic              load_done_q;
  logic              load_error_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              asm_accept;
  logic              asm_clear;
  logic [DATA_W-1:0] asm_word;
  logic              word_strobe;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  assign accept     = load_ready_q && load_valid;
  assign asm_accept = accept && !full_q;
  assign asm_clear  = load_start && ((state_q == ST_HOLD) || (state_q == ST_RUN));

  byte_word_assembler #(
    .DATA_W(DATA_W)
  ) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .accept_i     (asm_accept),
    .byte_i       (load_byte),
    .last_i       (load_last),
    .word_o       (asm_word),
    .word_strobe_o(word_strobe)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = asm_word;
    if (asm_accept && word_strobe) begin
      mem_we = 1'b1;
    end else if (state_q == ST_FILL) begin
      mem_we    = 1'b1;
      mem_wdata = DATA_W'(NOP_WORD);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      ptr_q        <= '0;
      full_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_HOLD, ST_RUN: begin
          if (load_start) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            full_q       <= 1'b0;
            load_error_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (full_q) begin
              // Array already full: byte is dropped, flag overflow.
              load_error_q <= 1'b1;
              if (load_last) begin
                state_q      <= ST_RUN;
                load_ready_q <= 1'b0;
                cpu_hold_q   <= 1'b0;
                load_done_q  <= 1'b1;
              end
            end else if (word_strobe) begin
              ptr_q <= ptr_q + ADDR_W'(1);
              if (ptr_q == PTR_MAX) begin
                full_q <= 1'b1;
              end
              if (load_last) begin
                load_ready_q <= 1'b0;
                if (ptr_q == PTR_MAX) begin
                  state_q     <= ST_RUN;
                  cpu_hold_q  <= 1'b0;
                  load_done_q <= 1'b1;
                end else begin
                  state_q <= ST_FILL;
                end
              end
            end
          end
        end
        ST_FILL: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == PTR_MAX) begin
            state_q     <= ST_RUN;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign instruction = cpu_hold_q ? '0 : mem_q[instruction_address];
  assign load_ready  = load_ready_q;
  assign cpu_hold    = cpu_hold_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign dbg_state_o = state_q;

endmodule
